mem_bus_arbiter: RTL and testbench

//  Shares the single external memory port between instruction fetch (I) and the

---
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory port between instruction fetch (I) and
// the data load/store path (D), with fetch cancellation and a bus watchdog.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_cancel,
    output logic                  if_ready,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_valid,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_ack,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  bus_error
);

    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state, state_next;
    owner_t            owner, owner_next;
    owner_t            last_grant, last_grant_next;
    logic [WD_W-1:0]   wd, wd_next;
    logic              if_done, if_done_next;
    logic              m_valid_next, m_we_next, bus_error_next;
    logic [BE_W-1:0]   m_be_next;
    logic [ADDR_W-1:0] m_addr_next;
    logic [DATA_W-1:0] m_wdata_next, if_rdata_next, d_rdata_next;
    logic              fetch_req, grant_d;

    // A fetch cancelled in the same cycle it is raised never competes for the bus.
    assign fetch_req = if_req & ~if_cancel;
    assign grant_d   = d_req & (~fetch_req | (last_grant == OWN_I));

    // The completion pulse is dropped if the pipeline flushes during the response cycle.
    assign if_ready = if_done & ~if_cancel;
    assign d_ready  = ~d_req | ((state == RESP) && (owner == OWN_D));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        wd_next         = wd;
        if_done_next    = 1'b0;
        bus_error_next  = 1'b0;
        m_valid_next    = m_valid;
        m_we_next       = m_we;
        m_be_next       = m_be;
        m_addr_next     = m_addr;
        m_wdata_next    = m_wdata;
        if_rdata_next   = if_rdata;
        d_rdata_next    = d_rdata;

        case (state)
            IDLE: begin
                if (fetch_req || d_req) begin
                    state_next   = BUSY;
                    owner_next   = grant_d ? OWN_D : OWN_I;
                    m_valid_next = 1'b1;
                    wd_next      = '0;
                    if (grant_d) begin
                        m_we_next    = d_we;
                        m_be_next    = d_we ? d_be : '1;
                        m_addr_next  = d_addr;
                        m_wdata_next = d_we ? d_wdata : '0;
                    end else begin
                        m_we_next    = 1'b0;
                        m_be_next    = '1;
                        m_addr_next  = if_addr;
                        m_wdata_next = '0;
                    end
                end
            end
            BUSY: begin
                if (m_ack) begin
                    m_valid_next = 1'b0;
                    state_next   = RESP;
                    if (owner == OWN_I) begin
                        if_rdata_next = m_rdata;
                        if_done_next  = ~if_cancel;
                    end else begin
                        d_rdata_next = m_rdata;
                    end
                end else if (wd == WD_LAST) begin
                    // Watchdog expiry still completes the access so the requester is released.
                    m_valid_next   = 1'b0;
                    bus_error_next = 1'b1;
                    state_next     = RESP;
                    if (owner == OWN_I) begin
                        if_rdata_next = '0;
                        if_done_next  = ~if_cancel;
                    end else begin
                        d_rdata_next = '0;
                    end
                end else begin
                    wd_next = wd + WD_ONE;
                    if ((owner == OWN_I) && if_cancel) begin
                        state_next = DRAIN;
                    end
                end
            end
            RESP: begin
                last_grant_next = owner;
                state_next      = IDLE;
            end
            DRAIN: begin
                if (m_ack) begin
                    m_valid_next = 1'b0;
                    state_next   = IDLE;
                end else if (wd == WD_LAST) begin
                    m_valid_next   = 1'b0;
                    bus_error_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    wd_next = wd + WD_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            wd         <= '0;
            if_done    <= 1'b0;
            bus_error  <= 1'b0;
            m_valid    <= 1'b0;
            m_we       <= 1'b0;
            m_be       <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            wd         <= wd_next;
            if_done    <= if_done_next;
            bus_error  <= bus_error_next;
            m_valid    <= m_valid_next;
            m_we       <= m_we_next;
            m_be       <= m_be_next;
            m_addr     <= m_addr_next;
            m_wdata    <= m_wdata_next;
            if_rdata   <= if_rdata_next;
            d_rdata    <= d_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a latency-programmable memory responder, a bus and
// response scoreboard, a vector table and hand-written multi-cycle sequences.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          resetn;
    logic          if_req, if_cancel, if_ready;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ready;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_valid, m_we, m_ack, bus_error;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_t;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] data;
        logic          chk;
    } resp_t;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            ack_dly;
        logic          exp_we;
        logic [3:0]    exp_be;
        logic [DW-1:0] exp_wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    bus_t  exp_bus[$];
    resp_t exp_resp[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    resp_cnt = 0;
    int    ack_delay = 0;
    bit    mem_enable = 1'b1;
    int    vcnt = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [79:0] actual, input logic [79:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: acks after ack_delay extra cycles of m_valid, junk data otherwise.
    initial begin
        m_ack   = 1'b0;
        m_rdata = 32'hBAD0_0000;
        forever begin
            @(posedge clk);
            #1;
            if (resetn && m_valid && mem_enable) begin
                if (vcnt == ack_delay) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_word(m_addr);
                    vcnt    = 0;
                end else begin
                    m_ack   = 1'b0;
                    m_rdata = 32'hBAD0_0000;
                    vcnt++;
                end
            end else begin
                m_ack   = 1'b0;
                m_rdata = 32'hBAD0_0000;
                vcnt    = 0;
            end
        end
    end

    logic        prev_valid = 1'b0;
    logic [68:0] prev_cmd   = '0;

    always @(negedge clk) begin
        if (resetn && m_valid && prev_valid)
            check("m_cmd_stable", {m_we, m_be, m_addr, m_wdata}, prev_cmd);
        prev_valid <= resetn & m_valid;
        prev_cmd   <= {m_we, m_be, m_addr, m_wdata};
    end

    always @(negedge clk) begin : bus_mon
        bus_t e;
        if (resetn && m_valid && m_ack) begin
            check("bus_expected", exp_bus.size() != 0, 1'b1);
            if (exp_bus.size() != 0) begin
                e = exp_bus.pop_front();
                check("bus_cmd", {m_we, m_be, m_addr, m_wdata}, {e.we, e.be, e.addr, e.wdata});
            end
        end
    end

    always @(negedge clk) begin : resp_mon
        resp_t r;
        if (resetn && if_ready) begin
            check("resp_expected_i", exp_resp.size() != 0, 1'b1);
            if (exp_resp.size() != 0) begin
                r = exp_resp.pop_front();
                check("resp_side_i", r.is_d, 1'b0);
                if (r.chk) check("if_rdata", if_rdata, r.data);
            end
            resp_cnt <= resp_cnt + 1;
        end
        if (resetn && d_req && d_ready) begin
            check("resp_expected_d", exp_resp.size() != 0, 1'b1);
            if (exp_resp.size() != 0) begin
                r = exp_resp.pop_front();
                check("resp_side_d", r.is_d, 1'b1);
                if (r.chk) check("d_rdata", d_rdata, r.data);
            end
            resp_cnt <= resp_cnt + 1;
        end
    end

    task automatic wait_resp(input int target, input int budget, input string name);
        int n = 0;
        while (resp_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, resp_cnt >= target, 1'b1);
    endtask

    task automatic apply_vec(input vec_t v);
        int target;
        ack_delay = v.ack_dly;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        exp_bus.push_back('{v.exp_we, v.exp_be, v.addr, v.exp_wdata});
        exp_resp.push_back('{v.is_d, v.exp_rdata, ~v.we});
        target = resp_cnt + 1;
        wait_resp(target, 40, "vec_done");
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "time limit exceeded");
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0,         0, 1'b0, 4'hf, 32'h0,    mem_word(32'h40)};
        vecs[1] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         2, 1'b0, 4'hf, 32'h0,    32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0200, 32'h1234,      2, 1'b1, 4'h3, 32'h1234, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 4'h5, 32'h0000_0204, 32'hFFFF_FFFF, 1, 1'b0, 4'hf, 32'h0,    mem_word(32'h204)};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0044, 32'h0,         5, 1'b0, 4'hf, 32'h0,    mem_word(32'h44)};
        vecs[5] = '{1'b1, 1'b1, 4'h8, 32'h0000_0208, 32'hCAFE_F00D, 0, 1'b1, 4'h8, 32'hCAFE_F00D, 32'h0};

        resetn = 1'b0; if_cancel = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h2000; d_wdata = '0;
        repeat (2) tick();

        // Reset state with both requests pending.
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_cmd", {m_we, m_be, m_addr, m_wdata}, 69'h0);
        check("rst_if", {if_ready, if_rdata}, 33'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_bus_error", bus_error, 1'b0);
        check("rst_d_ready", d_ready, 1'b0);

        // Contention from reset: D first, then alternating.
        ack_delay = 1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                exp_bus.push_back('{1'b0, 4'hf, 32'h2000, 32'h0});
                exp_resp.push_back('{1'b1, mem_word(32'h2000), 1'b1});
            end else begin
                exp_bus.push_back('{1'b0, 4'hf, 32'h1000, 32'h0});
                exp_resp.push_back('{1'b0, mem_word(32'h1000), 1'b1});
            end
        end
        resetn = 1'b1;
        wait_resp(4, 60, "contention_done");
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // A fetch raised together with if_cancel is not a request.
        if_req = 1'b1; if_cancel = 1'b1; if_addr = 32'h700;
        tick();
        check("cancelled_req_no_grant", m_valid, 1'b0);
        if_req = 1'b0; if_cancel = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Single load with 3-cycle ack delay; if_cancel while D owns the bus is ignored.
        ack_delay = 3;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h100;
        exp_bus.push_back('{1'b0, 4'hf, 32'h100, 32'h0});
        exp_resp.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1});
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("load_m_valid_c%0d", c), m_valid, (c <= 4));
            check($sformatf("load_d_ready_c%0d", c), d_ready, (c == 5));
            if (c == 2) if_cancel = 1'b1;
            if (c == 3) if_cancel = 1'b0;
            if (c == 5) begin
                check("load_d_rdata", d_rdata, 32'hDEAD_BEEF);
                d_req = 1'b0;
            end
        end
        tick();
        check("load_c6_m_valid", m_valid, 1'b0);
        check("load_c6_d_ready", d_ready, 1'b1);

        // Fetch cancelled in BUSY one cycle before ack, then a D load proves IDLE after ack.
        ack_delay = 3;
        if_req = 1'b1; if_addr = 32'h300;
        exp_bus.push_back('{1'b0, 4'hf, 32'h300, 32'h0});
        tick(); check("cancel_c1_m_valid", m_valid, 1'b1);
        tick(); check("cancel_c2_m_valid", m_valid, 1'b1);
        tick(); check("cancel_c3_m_valid", m_valid, 1'b1);
        if_cancel = 1'b1; if_req = 1'b0;
        tick(); check("cancel_c4_m_valid_held", m_valid, 1'b1);
        if_cancel = 1'b0;
        ack_delay = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        exp_bus.push_back('{1'b0, 4'hf, 32'h600, 32'h0});
        exp_resp.push_back('{1'b1, mem_word(32'h600), 1'b1});
        tick();
        check("cancel_c5_m_valid", m_valid, 1'b0);
        check("cancel_c5_if_ready", if_ready, 1'b0);
        tick();
        check("cancel_c6_regrant", {m_valid, m_addr}, {1'b1, 32'h600});
        tick();
        check("cancel_c7_d_ready", d_ready, 1'b1);
        d_req = 1'b0;
        tick();

        // Watchdog: no ack, TIMEOUT=8.
        mem_enable = 1'b0;
        d_req = 1'b1; d_addr = 32'h400;
        exp_resp.push_back('{1'b1, 32'h0, 1'b1});
        for (int c = 1; c <= 10; c++) begin
            tick();
            check($sformatf("wd_m_valid_c%0d", c), m_valid, (c <= 8));
            check($sformatf("wd_bus_error_c%0d", c), bus_error, (c == 9));
            if (c <= 9) check($sformatf("wd_d_ready_c%0d", c), d_ready, (c == 9));
            if (c == 9) begin
                check("wd_d_rdata", d_rdata, 32'h0);
                d_req = 1'b0;
            end
        end

        // Asynchronous reset in the middle of BUSY.
        d_req = 1'b1; d_addr = 32'h500;
        tick(); check("arst_c1_m_valid", m_valid, 1'b1);
        tick(); check("arst_c2_m_valid", m_valid, 1'b1);
        resetn = 1'b0;
        #1;
        check("arst_m_valid_now", m_valid, 1'b0);
        check("arst_m_addr_now", m_addr, 32'h0);
        d_req = 1'b0;
        #1;
        check("arst_d_ready_idle", d_ready, 1'b1);
        tick();
        resetn = 1'b1;
        mem_enable = 1'b1;
        tick();
        check("post_rst_m_valid", m_valid, 1'b0);
        check("post_rst_d_ready_low_req", d_ready, 1'b1);
        d_req = 1'b1;
        #1;
        check("post_rst_d_ready_high_req", d_ready, 1'b0);
        d_req = 1'b0;
        tick();
        check("post_rst_no_grant", m_valid, 1'b0);

        repeat (2) tick();
        check("bus_queue_drained", exp_bus.size(), 0);
        check("resp_queue_drained", exp_resp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
